// File: rtl/out_channel_pkg.sv
// out_channel_pkg: shared types and helpers for the program out-channel reader.
//   word_t     - one channel word (MemoryElementWidth bits)
//   state_t    - reader state machine encoding
//   nextIndex  - modulo-wrap increment by compare-and-clear, so buffer depths
//                that are not a power of two wrap correctly
package out_channel_pkg;

    localparam int MemoryElementWidth = 12;

    typedef logic [MemoryElementWidth-1:0] word_t;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        DONE  = 2'd2
    } state_t;

    function automatic int unsigned nextIndex(input int unsigned idx, input int unsigned limit);
        if (idx + 1 >= limit) begin
            return 0;
        end
        return idx + 1;
    endfunction

endpackage

// File: rtl/out_channel_reader_if.sv
// out_channel_reader_if: program-side write port and host-side drain port.
//   outValid/outData/outReady    - words emitted by the program's `out`
//   readValid/readData/readReady - valid/ready drain toward the host
// master: the program and host side; slave: the reader.
interface out_channel_reader_if import out_channel_pkg::*;;

    logic  outValid;
    word_t outData;
    logic  outReady;
    logic  readValid;
    word_t readData;
    logic  readReady;

    modport master (
        output outValid, outData, readReady,
        input  outReady, readValid, readData
    );

    modport slave (
        input  outValid, outData, readReady,
        output outReady, readValid, readData
    );

endinterface

// File: rtl/out_channel_fifo.sv
// out_channel_fifo: NOut-deep circular buffer with a sticky overflow flag.
//   clock, reset - rising-edge clock, asynchronous active-low reset
//   push_req     - write request; dropped (and overflow set) when full
//   push_data    - word to store
//   pop_req      - read request; ignored when empty
//   count        - words currently buffered
//   full, empty  - occupancy flags from the registered count
//   rd_data      - word at the read pointer
//   overflow     - set by a push while full, held until reset
// Storage is not reset; only pointers and count are, which is enough to
// discard contents.
module out_channel_fifo
    import out_channel_pkg::*;
#(
    parameter  int NOut = 4,
    localparam int CW   = $clog2(NOut + 1),
    localparam int PW   = (NOut > 1) ? $clog2(NOut) : 1
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          push_req,
    input  word_t         push_data,
    input  logic          pop_req,
    output logic [CW-1:0] count,
    output logic          full,
    output logic          empty,
    output word_t         rd_data,
    output logic          overflow
);

    word_t         mem_q [NOut];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          overflow_q, overflow_d;
    logic          push_ok;
    logic          pop_ok;

    assign full     = (count_q == CW'(NOut));
    assign empty    = (count_q == '0);
    assign count    = count_q;
    assign overflow = overflow_q;
    assign rd_data  = mem_q[rd_ptr_q];

    // Full is taken from the registered count, so a same-cycle pop never
    // makes room for a push that arrives while full.
    assign push_ok = push_req && !full;
    assign pop_ok  = pop_req && !empty;

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q | (push_req & full);
        if (push_ok) begin
            wr_ptr_d = PW'(nextIndex(32'(wr_ptr_q), NOut));
        end
        if (pop_ok) begin
            rd_ptr_d = PW'(nextIndex(32'(rd_ptr_q), NOut));
        end
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    always_ff @(posedge clock) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

endmodule

// File: rtl/out_channel_reader.sv
// out_channel_reader: consumer end of the program out channel.
// Buffers words from the program's `out` instruction, drains them to the host
// over a valid/ready port, and reports finished/success once the program has
// stopped and the buffer is empty.
//   clock, reset  - rising-edge clock, asynchronous active-low reset
//   bus (slave)   - outValid/outData/outReady and readValid/readData/readReady
//   programDone   - level: program has issued its last instruction
//   count         - words buffered
//   overflow      - sticky: a write arrived while full
//   expWrite/expAddr/expData/expCount - expected-value table load and the
//                   number of words the program must emit
//   finished      - program done and buffer drained (held until reset)
//   success       - valid with finished
// Optional build macro OUT_CHECK_EN adds the expected-value checker; without
// it the exp* inputs are ignored and success = !overflow.
//
// state | meaning
// RUN   | program running; pushes and pops allowed
// DRAIN | program done; pushes ignored, host empties the buffer
// DONE  | finished/success latched; pushes and pops ignored
module out_channel_reader
    import out_channel_pkg::*;
#(
    parameter  int NOut    = 4,
    parameter  int NExpect = 8,
    localparam int CW      = $clog2(NOut + 1),
    localparam int AW      = (NExpect > 1) ? $clog2(NExpect) : 1,
    localparam int EW      = $clog2(NExpect + 1)
) (
    input  logic                    clock,
    input  logic                    reset,
    out_channel_reader_if.slave     bus,
    input  logic                    programDone,
    output logic [CW-1:0]           count,
    output logic                    overflow,
    input  logic                    expWrite,
    input  logic [AW-1:0]           expAddr,
    input  word_t                   expData,
    input  logic [EW-1:0]           expCount,
    output logic                    finished,
    output logic                    success
);

    state_t        state_q, state_d;
    logic          finished_q, finished_d;
    logic          success_q, success_d;
    logic          read_valid;
    logic          push_req;
    logic          pop_req;
    logic          fifo_full;
    logic          fifo_empty;
    word_t         fifo_rd_data;
    logic [CW-1:0] fifo_count;
    logic          drained;
    logic          check_ok;

    assign read_valid = !fifo_empty && (state_q != DONE);
    assign push_req   = bus.outValid && (state_q == RUN);
    assign pop_req    = read_valid && bus.readReady;

    out_channel_fifo #(
        .NOut (NOut)
    ) u_fifo (
        .clock     (clock),
        .reset     (reset),
        .push_req  (push_req),
        .push_data (bus.outData),
        .pop_req   (pop_req),
        .count     (fifo_count),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .rd_data   (fifo_rd_data),
        .overflow  (overflow)
    );

    assign bus.outReady  = !fifo_full;
    assign bus.readValid = read_valid;
    // Storage is never cleared, so mask the data word while nothing is valid.
    assign bus.readData  = read_valid ? fifo_rd_data : '0;
    assign count         = fifo_count;
    assign finished      = finished_q;
    assign success       = success_q;

    // A final pop in the same cycle still counts as drained.
    assign drained = fifo_empty || ((fifo_count == CW'(1)) && pop_req);

`ifdef OUT_CHECK_EN
    word_t         exp_tab_q [NExpect];
    logic [EW-1:0] pop_index_q, pop_index_d;
    logic          mismatch_q, mismatch_d;

    always_ff @(posedge clock) begin
        if (expWrite && (32'(expAddr) < 32'(NExpect))) begin
            exp_tab_q[expAddr] <= expData;
        end
    end

    // pop_index saturates at NExpect; any pop past the table is a mismatch.
    always_comb begin
        pop_index_d = pop_index_q;
        mismatch_d  = mismatch_q;
        if (pop_req) begin
            if (32'(pop_index_q) >= 32'(NExpect)) begin
                mismatch_d = 1'b1;
            end else begin
                if (bus.readData != exp_tab_q[AW'(pop_index_q)]) begin
                    mismatch_d = 1'b1;
                end
                pop_index_d = pop_index_q + EW'(1);
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            pop_index_q <= '0;
            mismatch_q  <= 1'b0;
        end else begin
            pop_index_q <= pop_index_d;
            mismatch_q  <= mismatch_d;
        end
    end

    // Next-state values so a pop on the DRAIN->DONE edge is included.
    assign check_ok = !mismatch_d && (pop_index_d == expCount);
`else
    logic unused_exp;
    assign unused_exp = ^{expWrite, expAddr, expData, expCount};
    assign check_ok   = 1'b1;
`endif

    always_comb begin
        state_d    = state_q;
        finished_d = finished_q;
        success_d  = success_q;
        case (state_q)
            RUN: begin
                if (programDone) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (drained) begin
                    state_d    = DONE;
                    finished_d = 1'b1;
                    success_d  = !overflow && check_ok;
                end
            end
            DONE: begin
                state_d = DONE;
            end
            default: begin
                state_d = RUN;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= RUN;
            finished_q <= 1'b0;
            success_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            finished_q <= finished_d;
            success_q  <= success_d;
        end
    end

endmodule

// File: tb/tb_out_channel_reader.sv
// tb_out_channel_reader: directed bench for out_channel_reader (NOut = 4).
// Expected values are hand-computed constants; the OUT_CHECK_EN sections
// exercise the expected-value checker when that macro is defined.
module tb_out_channel_reader;
    import out_channel_pkg::*;

    localparam int NOut    = 4;
    localparam int NExpect = 8;

    logic       clock;
    logic       reset;
    logic       programDone;
    logic [2:0] count;
    logic       overflow;
    logic       expWrite;
    logic [2:0] expAddr;
    word_t      expData;
    logic [3:0] expCount;
    logic       finished;
    logic       success;

    int n_tests;
    int n_fail;

    out_channel_reader_if bus ();

    out_channel_reader #(
        .NOut    (NOut),
        .NExpect (NExpect)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .bus         (bus.slave),
        .programDone (programDone),
        .count       (count),
        .overflow    (overflow),
        .expWrite    (expWrite),
        .expAddr     (expAddr),
        .expData     (expData),
        .expCount    (expCount),
        .finished    (finished),
        .success     (success)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        programDone   = 1'b0;
        bus.outValid  = 1'b0;
        bus.readReady = 1'b0;
        #2 reset = 1'b0;
        #2 reset = 1'b1;
    endtask

    task automatic push(input logic [11:0] d);
        bus.outValid = 1'b1;
        bus.outData  = d;
        tick();
        bus.outValid = 1'b0;
    endtask

    initial begin
        n_tests       = 0;
        n_fail        = 0;
        reset         = 1'b0;
        programDone   = 1'b0;
        bus.outValid  = 1'b0;
        bus.outData   = '0;
        bus.readReady = 1'b0;
        expWrite      = 1'b0;
        expAddr       = '0;
        expData       = '0;
        expCount      = '0;
        #12;
        check("rst_count", 32'(count), 0);
        check("rst_read_valid", 32'(bus.readValid), 0);
        check("rst_read_data", 32'(bus.readData), 0);
        check("rst_out_ready", 32'(bus.outReady), 1);
        check("rst_overflow", 32'(overflow), 0);
        check("rst_finished", 32'(finished), 0);
        check("rst_success", 32'(success), 0);
        reset = 1'b1;
        #1;

`ifdef OUT_CHECK_EN
        expWrite = 1'b1;
        expAddr = 3'd0; expData = 12'd2; tick();
        expAddr = 3'd1; expData = 12'd4; tick();
        expWrite = 1'b0;
        expCount = 4'd1;
`endif

        // 1: single word
        push(12'd2);
        check("t1_count", 32'(count), 1);
        check("t1_read_valid", 32'(bus.readValid), 1);
        check("t1_read_data", 32'(bus.readData), 2);
        bus.readReady = 1'b1;
        programDone   = 1'b1;
        tick();
        check("t1_count_after_pop", 32'(count), 0);
        check("t1_not_finished_yet", 32'(finished), 0);
        tick();
        check("t1_finished", 32'(finished), 1);
        check("t1_success", 32'(success), 1);
        check("t1_done_read_valid", 32'(bus.readValid), 0);

        // 2: fill and wrap
        do_reset();
        push(12'd1); push(12'd2); push(12'd3); push(12'd4);
        check("t2_count_full", 32'(count), 4);
        check("t2_out_ready_full", 32'(bus.outReady), 0);
        check("t2_head", 32'(bus.readData), 1);
        bus.readReady = 1'b1;
        tick();
        check("t2_pop1_data", 32'(bus.readData), 2);
        tick();
        check("t2_pop2_count", 32'(count), 2);
        bus.readReady = 1'b0;
        push(12'd5);
        push(12'd6);
        check("t2_refill_count", 32'(count), 4);
        bus.readReady = 1'b1;
        check("t2_rd3", 32'(bus.readData), 3); tick();
        check("t2_rd4", 32'(bus.readData), 4); tick();
        check("t2_rd5", 32'(bus.readData), 5); tick();
        check("t2_rd6", 32'(bus.readData), 6); tick();
        check("t2_empty_count", 32'(count), 0);
        check("t2_empty_valid", 32'(bus.readValid), 0);

        // 4: simultaneous push/pop at count = 2
        bus.readReady = 1'b0;
        push(12'd10);
        push(12'd11);
        bus.outValid  = 1'b1;
        bus.outData   = 12'd7;
        bus.readReady = 1'b1;
        tick();
        bus.outValid  = 1'b0;
        check("t4_count_same", 32'(count), 2);
        check("t4_next", 32'(bus.readData), 11);
        tick();
        check("t4_last", 32'(bus.readData), 7);
        tick();
        check("t4_empty", 32'(count), 0);

        // 3: overflow while popping
        bus.readReady = 1'b0;
        push(12'd20); push(12'd21); push(12'd22); push(12'd23);
        bus.outValid  = 1'b1;
        bus.outData   = 12'd9;
        bus.readReady = 1'b1;
        tick();
        bus.outValid  = 1'b0;
        check("t3_count", 32'(count), 3);
        check("t3_overflow", 32'(overflow), 1);
        check("t3_rd21", 32'(bus.readData), 21); tick();
        check("t3_rd22", 32'(bus.readData), 22); tick();
        check("t3_rd23", 32'(bus.readData), 23); tick();
        check("t3_dropped", 32'(bus.readValid), 0);
        bus.readReady = 1'b0;
        programDone   = 1'b1;
        tick();
        tick();
        check("t3_finished", 32'(finished), 1);
        check("t3_success", 32'(success), 0);
        push(12'd8);
        check("t3_done_ignores_push", 32'(count), 0);
        check("t3_done_held", 32'(finished), 1);

        // 6: reset mid-drain
        do_reset();
        push(12'd30); push(12'd31); push(12'd32);
        programDone = 1'b1;
        tick();
        push(12'd33);
        check("t6_drain_ignores_push", 32'(count), 3);
        check("t6_drain_no_overflow", 32'(overflow), 0);
        check("t6_drain_valid", 32'(bus.readValid), 1);
        #2 reset = 1'b0;
        #1;
        check("t6_rst_count", 32'(count), 0);
        check("t6_rst_valid", 32'(bus.readValid), 0);
        check("t6_rst_finished", 32'(finished), 0);
        check("t6_rst_success", 32'(success), 0);
        programDone = 1'b0;
        #1 reset = 1'b1;
        check("t6_state_run", 32'(dut.state_q), 32'(RUN));
        push(12'd40);
        check("t6_push_after", 32'(count), 1);
        check("t6_data_after", 32'(bus.readData), 40);

`ifdef OUT_CHECK_EN
        // 5: mismatching word, then too few words
        expCount = 4'd2;
        do_reset();
        push(12'd2);
        push(12'd5);
        bus.readReady = 1'b1;
        programDone   = 1'b1;
        tick();
        tick();
        check("t5_mis_finished", 32'(finished), 1);
        check("t5_mis_success", 32'(success), 0);
        do_reset();
        push(12'd2);
        bus.readReady = 1'b1;
        programDone   = 1'b1;
        tick();
        tick();
        check("t5_short_finished", 32'(finished), 1);
        check("t5_short_success", 32'(success), 0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
